cpu_axi_bridge: RTL and testbench
=================================

Name: cpu_axi_bridge

Overview:
- Converts the pipeline's two SRAM-like master ports (instruction fetch and data memory) into one AXI3 master port.
- Sits between the IF/MEM stages and the SoC AXI interconnect.
- Arbitrates a shared AR channel, steers R beats back by ID, and runs writes on AW/W/B.
- Single-beat transfers only.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_sram_req/wr  in  1/1  instruction request, write flag (always 0 from IF)
- inst_sram_size  in  2  0=byte 1=half 2=word
- inst_sram_wstrb  in  4  byte strobes (unused for reads)
- inst_sram_addr/wdata  in  32/32  request address, write data
- inst_sram_addr_ok/data_ok  out  1/1  request accepted / response valid
- inst_sram_rdata  out  32  read data
- data_sram_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  as above, data side
- data_sram_addr_ok/data_ok/rdata  out  1/1/32  as above, data side
- arid/araddr/arsize  out  4/32/3  AR payload
- arvalid/arready  out/in  1/1  AR handshake
- rid/rdata/rresp/rlast  in  4/32/2/1  R payload
- rvalid/rready  in/out  1/1  R handshake
- awid/awaddr/awsize  out  4/32/3  AW payload
- awvalid/awready  out/in  1/1  AW handshake
- wid/wdata/wstrb/wlast  out  4/32/4/1  W payload
- wvalid/wready  out/in  1/1  W handshake
- bid/bresp  in  4/2  B payload
- bvalid/bready  in/out  1/1  B handshake
- arlen/arburst/arlock/arcache/arprot, same set on aw  out  8/2/2/4/3  constants 0/1/0/0/0

Behaviour:
- Reset values: all valid/ready outputs 0, addr_ok/data_ok 0, rdata 0, payload registers 0.
- IDs: arid=0 for inst, 1 for data; awid=wid=1.
- axsize = {1'b0, size}. wlast=1.
- Read request FSM: AR_IDLE -> AR_SEND -> AR_IDLE.
  - In AR_IDLE, a request is eligible if req && !wr and its source has no outstanding read.
  - Data side wins ties.
  - A data read is also ineligible while any write is outstanding (RAW hazard).
  - On acceptance: pulse that port's addr_ok for exactly that cycle, latch id/addr/size, enter AR_SEND with arvalid=1.
  - AR_SEND holds the payload stable until arready, then returns to AR_IDLE.
  - Latency: addr_ok in the cycle req is sampled eligible; arvalid the next cycle.
- Outstanding-read flags, one per source:
  - Set on addr_ok.
  - Cleared on R handshake with matching rid.
  - addr_ok for a source is held 0 while its flag is set, so there is at most one outstanding read per source.
- R channel:
  - rready=1 whenever any read is outstanding.
  - On rvalid&&rready, register rdata and pulse data_ok on the port selected by rid[0] the next cycle. Response latency is 1 cycle after the R beat.
  - Data and inst data_ok may pulse in consecutive cycles; never both in the same cycle.
- Write FSM: W_IDLE -> W_SEND -> W_RESP -> W_IDLE.
  - In W_IDLE, data req && wr accepts only if no data read is outstanding. Inst writes are never accepted.
  - Write acceptance has priority over the AR path for the data port within the same cycle.
  - On acceptance: pulse data addr_ok, latch payload, raise awvalid and wvalid together.
  - Each valid drops independently on its own ready.
  - W_RESP is entered when both have handshaked (same or different cycles). bready=1 in W_RESP.
  - On bvalid: pulse data data_ok next cycle, then W_IDLE.
  - bresp and rresp are ignored.
- Reset mid-transaction: all FSMs and flags return to idle and pending responses are discarded. The interconnect is reset by the same signal.
- No request cancellation. IF discards flushed responses itself, so every accepted request gets exactly one data_ok.

Decomposition:
- Shared package `axi_pkg` holds:
  - ID_INST=0, ID_DATA=1
  - AXI constant sideband values
  - FSM state encodings
- Natural sub-module: `axi_write_ctrl` (write FSM, AW/W/B). The read arbiter and R demux stay in the top.

Test Plan:
- Inst read 0x1c000000: addr_ok same cycle, arvalid next cycle with arid=0; after rdata=0x02800c04 with rid=0, inst data_ok=1 with rdata=0x02800c04 exactly one cycle later.
- Simultaneous inst read 0x1c000004 and data read 0x1c010000: data addr_ok first with arid=1; inst accepted the cycle after AR returns idle. R returned out of order (rid=0 then rid=1): each data_ok reaches the correct port.
- Inst req held while its read is outstanding -> inst_addr_ok stays 0 until one cycle after the matching R beat.
- Data write 0x1c010000, wdata 0xdeadbeef, wstrb 0x3, with awready delayed 3 cycles and wready immediate: wvalid drops after 1 cycle, awvalid persists, data_ok one cycle after bvalid. A data read issued meanwhile gets no addr_ok until then.
- Reset asserted while AR_SEND and a write are pending: next cycle all valids, readys and ok signals are 0; a fresh read then completes normally.
- arready held low for 10 cycles: araddr/arid/arsize remain stable throughout, and no second addr_ok pulse occurs.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared IDs, AXI sideband constants and FSM encodings for the CPU AXI bridge
package axi_pkg;
   localparam logic [3:0] ID_INST  = 4'd0;
   localparam logic [3:0] ID_DATA  = 4'd1;
   localparam logic [7:0] AX_LEN   = 8'd0;
   localparam logic [1:0] AX_BURST = 2'd1;
   localparam logic [1:0] AX_LOCK  = 2'd0;
   localparam logic [3:0] AX_CACHE = 4'd0;
   localparam logic [2:0] AX_PROT  = 3'd0;
   typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
endpackage

// File: rtl/axi_write_ctrl.sv
// axi_write_ctrl: single-beat data-port write engine driving AW/W/B
module axi_write_ctrl import axi_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                rd_busy,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [1:0]          size,
   input  logic [DATA_W-1:0]   wdata_in,
   input  logic [DATA_W/8-1:0] wstrb_in,
   output logic                acc,
   output logic                busy,
   output logic                data_ok,
   output logic [3:0]          awid,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [2:0]          awsize,
   output logic                awvalid,
   input  logic                awready,
   output logic [3:0]          wid,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic                bvalid,
   output logic                bready
);
   w_state_t state, state_nx;
   logic aw_pend, w_pend;
   assign acc     = state == W_IDLE && req && !rd_busy;
   assign busy    = state != W_IDLE;
   assign awvalid = aw_pend;
   assign wvalid  = w_pend;
   assign bready  = state == W_RESP;
   assign awid    = ID_DATA;
   assign wid     = ID_DATA;
   assign wlast   = 1'b1;
   // state register
   always_ff @(posedge clk)
      state <= reset ? W_IDLE : state_nx;
   // advance to W_RESP once both AW and W have handshaked, in either order
   always_comb begin
      state_nx = state;
      if (state == W_IDLE && acc) state_nx = W_SEND;
      else if (state == W_SEND && (!aw_pend || awready) && (!w_pend || wready)) state_nx = W_RESP;
      else if (state == W_RESP && bvalid) state_nx = W_IDLE;
   end
   // independent AW/W valids, latched payload, and the data_ok pulse after B
   always_ff @(posedge clk) begin
      if (reset) begin
         aw_pend <= 1'b0;
         w_pend  <= 1'b0;
         data_ok <= 1'b0;
         awaddr  <= '0;
         awsize  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
      end else begin
         aw_pend <= acc | (aw_pend & !awready);
         w_pend  <= acc | (w_pend & !wready);
         data_ok <= state == W_RESP && bvalid;
         if (acc) begin
            awaddr <= addr;
            awsize <= {1'b0, size};
            wdata  <= wdata_in;
            wstrb  <= wstrb_in;
         end
      end
   end
endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: joins the IF and MEM SRAM-like ports onto one single-beat AXI3 master
module cpu_axi_bridge import axi_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inst_sram_req,
   input  logic                inst_sram_wr,
   input  logic [1:0]          inst_sram_size,
   input  logic [DATA_W/8-1:0] inst_sram_wstrb,
   input  logic [ADDR_W-1:0]   inst_sram_addr,
   input  logic [DATA_W-1:0]   inst_sram_wdata,
   output logic                inst_sram_addr_ok,
   output logic                inst_sram_data_ok,
   output logic [DATA_W-1:0]   inst_sram_rdata,
   input  logic                data_sram_req,
   input  logic                data_sram_wr,
   input  logic [1:0]          data_sram_size,
   input  logic [DATA_W/8-1:0] data_sram_wstrb,
   input  logic [ADDR_W-1:0]   data_sram_addr,
   input  logic [DATA_W-1:0]   data_sram_wdata,
   output logic                data_sram_addr_ok,
   output logic                data_sram_data_ok,
   output logic [DATA_W-1:0]   data_sram_rdata,
   output logic [3:0]          arid,
   output logic [ADDR_W-1:0]   araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic [1:0]          arlock,
   output logic [3:0]          arcache,
   output logic [2:0]          arprot,
   output logic                arvalid,
   input  logic                arready,
   input  logic [3:0]          rid,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,
   output logic [3:0]          awid,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic [1:0]          awlock,
   output logic [3:0]          awcache,
   output logic [2:0]          awprot,
   output logic                awvalid,
   input  logic                awready,
   output logic [3:0]          wid,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [3:0]          bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);
   ar_state_t ar_state, ar_nx;
   logic inst_out, data_out, w_acc, w_busy, w_dok, r_dok, r_hs, d_el, i_el, rd_d, rd_i;
   logic [DATA_W-1:0] rdata_q;
   logic unused_ok;
   assign unused_ok = ^{bid, bresp, rresp, rlast, rid[3:1], inst_sram_wstrb, inst_sram_wdata};
   assign {arlen, arburst, arlock, arcache, arprot} = {AX_LEN, AX_BURST, AX_LOCK, AX_CACHE, AX_PROT};
   assign {awlen, awburst, awlock, awcache, awprot} = {AX_LEN, AX_BURST, AX_LOCK, AX_CACHE, AX_PROT};
   // a data read waits for any write in flight so it cannot overtake it
   assign d_el = !reset && data_sram_req && !data_sram_wr && !data_out && !w_busy;
   assign i_el = !reset && inst_sram_req && !inst_sram_wr && !inst_out;
   assign rd_d = ar_state == AR_IDLE && d_el;
   assign rd_i = ar_state == AR_IDLE && i_el && !d_el;
   assign inst_sram_addr_ok = rd_i;
   assign data_sram_addr_ok = rd_d | w_acc;
   assign arvalid = ar_state == AR_SEND;
   assign rready  = inst_out | data_out;
   assign r_hs    = rvalid && rready;
   assign inst_sram_rdata   = rdata_q;
   assign data_sram_rdata   = rdata_q;
   assign data_sram_data_ok = r_dok | w_dok;
   // AR state register
   always_ff @(posedge clk)
      ar_state <= reset ? AR_IDLE : ar_nx;
   // hold AR until the interconnect takes it
   always_comb begin
      ar_nx = ar_state == AR_IDLE ? ((rd_d || rd_i) ? AR_SEND : AR_IDLE) : (arready ? AR_IDLE : AR_SEND);
   end
   // AR payload, per-source outstanding flags, and R beat capture steered by rid[0]
   always_ff @(posedge clk) begin
      if (reset) begin
         arid              <= '0;
         araddr            <= '0;
         arsize            <= '0;
         inst_out          <= 1'b0;
         data_out          <= 1'b0;
         rdata_q           <= '0;
         inst_sram_data_ok <= 1'b0;
         r_dok             <= 1'b0;
      end else begin
         if (rd_d || rd_i) begin
            arid   <= rd_d ? ID_DATA : ID_INST;
            araddr <= rd_d ? data_sram_addr : inst_sram_addr;
            arsize <= {1'b0, rd_d ? data_sram_size : inst_sram_size};
         end
         inst_out          <= rd_i | (inst_out & !(r_hs && !rid[0]));
         data_out          <= rd_d | (data_out & !(r_hs && rid[0]));
         inst_sram_data_ok <= r_hs && !rid[0];
         r_dok             <= r_hs && rid[0];
         if (r_hs) rdata_q <= rdata;
      end
   end
   axi_write_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
      .clk(clk), .reset(reset), .req(!reset && data_sram_req && data_sram_wr), .rd_busy(data_out),
      .addr(data_sram_addr), .size(data_sram_size), .wdata_in(data_sram_wdata), .wstrb_in(data_sram_wstrb),
      .acc(w_acc), .busy(w_busy), .data_ok(w_dok),
      .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed checks of the CPU AXI bridge
module tb_cpu_axi_bridge;
   logic clk = 0, reset = 1;
   logic inst_sram_req = 0, inst_sram_wr = 0;
   logic [1:0] inst_sram_size = 0;
   logic [3:0] inst_sram_wstrb = 0;
   logic [31:0] inst_sram_addr = 0, inst_sram_wdata = 0;
   logic inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic data_sram_req = 0, data_sram_wr = 0;
   logic [1:0] data_sram_size = 0;
   logic [3:0] data_sram_wstrb = 0;
   logic [31:0] data_sram_addr = 0, data_sram_wdata = 0;
   logic data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [3:0] arid, awid, wid, arcache, awcache;
   logic [31:0] araddr, awaddr, wdata;
   logic [7:0] arlen, awlen;
   logic [2:0] arsize, awsize, arprot, awprot;
   logic [1:0] arburst, arlock, awburst, awlock;
   logic arvalid, rready, awvalid, wvalid, wlast, bready;
   logic [3:0] wstrb;
   logic arready = 0, rvalid = 0, rlast = 1, awready = 0, wready = 0, bvalid = 0;
   logic [3:0] rid = 0, bid = 1;
   logic [31:0] rdata = 0;
   logic [1:0] rresp = 0, bresp = 0;
   int n_tests = 0, n_fail = 0;

   cpu_axi_bridge dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
      .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
      .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
      .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic quiet(input string tag);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_awvalid"}, awvalid, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_rready"}, rready, 0);
      chk({tag, "_bready"}, bready, 0);
      chk({tag, "_i_aok"}, inst_sram_addr_ok, 0);
      chk({tag, "_d_aok"}, data_sram_addr_ok, 0);
      chk({tag, "_i_dok"}, inst_sram_data_ok, 0);
      chk({tag, "_d_dok"}, data_sram_data_ok, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(); cyc(); settle();
      quiet("rst");
      chk("rst_rdata", inst_sram_rdata, 0);
      chk("rst_araddr", araddr, 0);
      chk("arlen", arlen, 0);
      chk("arburst", arburst, 1);
      chk("awburst", awburst, 1);
      chk("wlast", wlast, 1);
      reset = 0;
      // single inst read
      cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2; settle();
      chk("t1_aok", inst_sram_addr_ok, 1);
      chk("t1_arvalid0", arvalid, 0);
      cyc(); inst_sram_req = 0; arready = 1; settle();
      chk("t1_arvalid", arvalid, 1);
      chk("t1_arid", arid, 0);
      chk("t1_araddr", araddr, 32'h1c000000);
      chk("t1_arsize", arsize, 2);
      cyc(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h02800c04; settle();
      chk("t1_arvalid_off", arvalid, 0);
      chk("t1_rready", rready, 1);
      chk("t1_dok_early", inst_sram_data_ok, 0);
      cyc(); rvalid = 0; settle();
      chk("t1_dok", inst_sram_data_ok, 1);
      chk("t1_rdata", inst_sram_rdata, 32'h02800c04);
      chk("t1_d_dok", data_sram_data_ok, 0);
      cyc(); settle();
      chk("t1_dok_off", inst_sram_data_ok, 0);
      chk("t1_rready_off", rready, 0);
      // simultaneous reads, out-of-order returns
      cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1c000004;
      data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c010000; data_sram_size = 2; settle();
      chk("t2_d_aok", data_sram_addr_ok, 1);
      chk("t2_i_aok0", inst_sram_addr_ok, 0);
      cyc(); data_sram_req = 0; arready = 1; settle();
      chk("t2_arid_d", arid, 1);
      chk("t2_araddr_d", araddr, 32'h1c010000);
      chk("t2_i_aok_busy", inst_sram_addr_ok, 0);
      cyc(); arready = 0; settle();
      chk("t2_i_aok", inst_sram_addr_ok, 1);
      cyc(); inst_sram_req = 0; arready = 1; settle();
      chk("t2_arid_i", arid, 0);
      chk("t2_araddr_i", araddr, 32'h1c000004);
      cyc(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h11111111;
      cyc(); rid = 1; rdata = 32'h22222222; settle();
      chk("t2_i_dok", inst_sram_data_ok, 1);
      chk("t2_d_dok0", data_sram_data_ok, 0);
      chk("t2_i_rdata", inst_sram_rdata, 32'h11111111);
      cyc(); rvalid = 0; settle();
      chk("t2_d_dok", data_sram_data_ok, 1);
      chk("t2_i_dok0", inst_sram_data_ok, 0);
      chk("t2_d_rdata", data_sram_rdata, 32'h22222222);
      // inst req held while outstanding
      cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1c000008; settle();
      chk("t3_aok", inst_sram_addr_ok, 1);
      cyc(); arready = 1; settle();
      chk("t3_hold_send", inst_sram_addr_ok, 0);
      cyc(); arready = 0; settle();
      chk("t3_hold_idle", inst_sram_addr_ok, 0);
      cyc(); rvalid = 1; rid = 0; rdata = 32'h33333333; settle();
      chk("t3_hold_beat", inst_sram_addr_ok, 0);
      cyc(); rvalid = 0; settle();
      chk("t3_reaccept", inst_sram_addr_ok, 1);
      chk("t3_dok", inst_sram_data_ok, 1);
      cyc(); inst_sram_req = 0; arready = 1;
      cyc(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h0;
      cyc(); rvalid = 0;
      cyc(); settle();
      chk("t3_drained", rready, 0);
      // write with delayed awready, plus blocked data read
      cyc(); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c010000;
      data_sram_wdata = 32'hdeadbeef; data_sram_wstrb = 4'h3; data_sram_size = 2; settle();
      chk("t4_aok", data_sram_addr_ok, 1);
      cyc(); data_sram_req = 0; data_sram_wr = 0; wready = 1; settle();
      chk("t4_awvalid", awvalid, 1);
      chk("t4_wvalid", wvalid, 1);
      chk("t4_awaddr", awaddr, 32'h1c010000);
      chk("t4_wdata", wdata, 32'hdeadbeef);
      chk("t4_wstrb", wstrb, 4'h3);
      chk("t4_awid", awid, 1);
      chk("t4_wid", wid, 1);
      chk("t4_awsize", awsize, 2);
      cyc(); wready = 0; data_sram_req = 1; data_sram_addr = 32'h1c010004; settle();
      chk("t4_wvalid_off", wvalid, 0);
      chk("t4_awvalid_c2", awvalid, 1);
      chk("t4_raw_c2", data_sram_addr_ok, 0);
      cyc(); settle();
      chk("t4_raw_c3", data_sram_addr_ok, 0);
      cyc(); awready = 1; settle();
      chk("t4_awvalid_c4", awvalid, 1);
      chk("t4_raw_c4", data_sram_addr_ok, 0);
      cyc(); awready = 0; bvalid = 1; settle();
      chk("t4_awvalid_off", awvalid, 0);
      chk("t4_bready", bready, 1);
      chk("t4_raw_resp", data_sram_addr_ok, 0);
      chk("t4_dok_early", data_sram_data_ok, 0);
      cyc(); bvalid = 0; settle();
      chk("t4_dok", data_sram_data_ok, 1);
      chk("t4_bready_off", bready, 0);
      chk("t4_rd_aok", data_sram_addr_ok, 1);
      cyc(); data_sram_req = 0; arready = 1; settle();
      chk("t4_dok_off", data_sram_data_ok, 0);
      chk("t4_rd_araddr", araddr, 32'h1c010004);
      cyc(); arready = 0; rvalid = 1; rid = 1; rdata = 32'h44444444;
      cyc(); rvalid = 0; settle();
      chk("t4_rd_dok", data_sram_data_ok, 1);
      chk("t4_rd_rdata", data_sram_rdata, 32'h44444444);
      // reset mid-transaction
      cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1c00000c;
      data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c010008; settle();
      chk("t5_i_aok", inst_sram_addr_ok, 1);
      chk("t5_d_aok", data_sram_addr_ok, 1);
      cyc(); inst_sram_req = 0; data_sram_req = 0; data_sram_wr = 0; settle();
      chk("t5_arvalid", arvalid, 1);
      chk("t5_awvalid", awvalid, 1);
      reset = 1;
      cyc(); reset = 0; settle();
      quiet("t5_post");
      cyc(); data_sram_req = 1; data_sram_addr = 32'h1c020000; settle();
      chk("t5_fresh_aok", data_sram_addr_ok, 1);
      cyc(); data_sram_req = 0; arready = 1; settle();
      chk("t5_fresh_araddr", araddr, 32'h1c020000);
      chk("t5_fresh_arid", arid, 1);
      cyc(); arready = 0; rvalid = 1; rid = 1; rdata = 32'h55555555;
      cyc(); rvalid = 0; settle();
      chk("t5_fresh_dok", data_sram_data_ok, 1);
      chk("t5_fresh_rdata", data_sram_rdata, 32'h55555555);
      // arready stalled for 10 cycles
      cyc(); inst_sram_req = 1; inst_sram_addr = 32'h1c000010; inst_sram_size = 1; settle();
      chk("t6_aok", inst_sram_addr_ok, 1);
      for (int i = 0; i < 10; i++) begin
         cyc(); settle();
         chk("t6_arvalid", arvalid, 1);
         chk("t6_araddr", araddr, 32'h1c000010);
         chk("t6_arid", arid, 0);
         chk("t6_arsize", arsize, 1);
         chk("t6_no_aok", inst_sram_addr_ok, 0);
      end
      inst_sram_req = 0; arready = 1;
      cyc(); arready = 0; settle();
      chk("t6_arvalid_off", arvalid, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
